i2s_rx_frame: RTL

- Upstream source for the adaptive filter stage.
- Oversamples an external I2S stream (bclk, lrclk, sdata) on the system clock and deserialises one selected channel into a parallel two's-complement word.
- Emits a single-cycle sample_trig with the word, matching the filter's data_in / sample_trig interface.
- One word per audio frame; the filter's 5-cycle processing fits easily between triggers.

---
 rtl/i2s_rx_frame_pkg.sv | 19 +
 rtl/i2s_rx_frame_if.sv | 25 ++
 rtl/i2s_rx_frame_sync_edge.sv | 51 +++++
 rtl/i2s_rx_frame.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/i2s_rx_frame_pkg.sv
// Shared definitions for the I2S frame receiver.
//   DEFAULT_DATA_WIDTH : default output word width
//   STATE_W / state_e  : receiver state encoding
//   CH_LEFT / CH_RIGHT : lrclk level that selects each channel
package i2s_pkg;
   localparam int DEFAULT_DATA_WIDTH = 24;
   localparam int STATE_W            = 3;

   typedef enum logic [STATE_W-1:0] {
      WAIT_CH = 3'd0,
      SKIP    = 3'd1,
      SHIFT   = 3'd2,
      EMIT    = 3'd3,
      HOLD    = 3'd4
   } state_e;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_rx_frame_if.sv
// Bus between the I2S pins / filter side and the frame receiver.
//   i2s_bclk, i2s_lrclk, i2s_sdata : raw I2S pins (driven by master)
//   data_out, sample_trig, frame_err : captured word and status (driven by slave)
interface i2s_rx_frame_if
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic                  i2s_bclk;
   logic                  i2s_lrclk;
   logic                  i2s_sdata;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  sample_trig;
   logic                  frame_err;

   modport master (
      output i2s_bclk, i2s_lrclk, i2s_sdata,
      input  data_out, sample_trig, frame_err
   );

   modport slave (
      input  i2s_bclk, i2s_lrclk, i2s_sdata,
      output data_out, sample_trig, frame_err
   );
endinterface

// File: rtl/i2s_rx_frame_sync_edge.sv
// Multi-flop synchroniser for asynchronous pins, with rising-edge detect
// on one of them.
//   clk, reset : system clock, synchronous active-high reset
//   edge_in    : pin whose rising edge is reported on rise
//   data_in    : pins that only need synchronising
//   rise       : one-clk pulse, synced edge_in high and previous value low
//   data_sync  : synchronised data_in
// STAGES must be at least 2.
module sync_edge #(
   parameter int WIDTH  = 2,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             edge_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             rise,
   output logic [WIDTH-1:0] data_sync
);
   localparam int N = WIDTH + 1;

   logic [N-1:0] sync_q [STAGES];
   logic [N-1:0] sync_d [STAGES];
   logic         prev_q;
   logic         prev_d;

   always_comb begin
      sync_d[0] = {data_in, edge_in};
      for (int s = 1; s < STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      prev_d = sync_q[STAGES-1][0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= '0;
         end
         prev_q <= 1'b0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
         prev_q <= prev_d;
      end
   end

   assign rise      = sync_q[STAGES-1][0] & ~prev_q;
   assign data_sync = sync_q[STAGES-1][N-1:1];
endmodule

// File: rtl/i2s_rx_frame.sv
// I2S receiver: oversamples bclk/lrclk/sdata on clk and deserialises one
// channel into a left-aligned DATA_WIDTH word with a one-clk sample_trig.
//   clk, reset : system clock (>= 8x bclk), synchronous active-high reset
//   bus        : slave side of i2s_rx_frame_if (pins in, data_out /
//                sample_trig / frame_err out)
// Parameters: DATA_WIDTH, CHANNEL (0 = left/lrclk low, 1 = right),
//             SYNC_STAGES (>= 2).
// Build option: I2S_RX_LEFT_JUSTIFIED_EN selects left-justified framing
// (no one-bit delay after the lrclk edge); default is standard I2S.
//
// state   | meaning
// WAIT_CH | waiting for an lrclk edge into the selected channel
// SKIP    | I2S one-bit delay slot before the MSB
// SHIFT   | shifting word bits in, MSB first
// EMIT    | one clk: publish word, pulse sample_trig
// HOLD    | discarding surplus bits until the next lrclk edge
module i2s_rx_frame
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int CHANNEL     = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   i2s_rx_frame_if.slave bus
);
   localparam int             CW       = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(DATA_WIDTH);
   localparam logic           SEL_LR   = (CHANNEL == 0) ? CH_LEFT : CH_RIGHT;

   logic       bclk_rise;
   logic [1:0] pins_sync;
   logic       lrclk_s;
   logic       sdata_s;

   sync_edge #(
      .WIDTH  (2),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .edge_in   (bus.i2s_bclk),
      .data_in   ({bus.i2s_sdata, bus.i2s_lrclk}),
      .rise      (bclk_rise),
      .data_sync (pins_sync)
   );

   assign lrclk_s = pins_sync[0];
   assign sdata_s = pins_sync[1];

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  lr_prev_q, lr_prev_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  trig_q, trig_d;
   logic                  err_q, err_d;

   logic                  lr_edge;
   logic                  ch_start;
   logic [DATA_WIDTH-1:0] shift_in;
   logic [CW-1:0]         cnt_inc;

   assign lr_edge  = bclk_rise && (lrclk_s != lr_prev_q);
   assign ch_start = lr_edge && (lrclk_s == SEL_LR);
   assign shift_in = {shift_q[DATA_WIDTH-2:0], sdata_s};
   assign cnt_inc  = cnt_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      lr_prev_d = lr_prev_q;
      data_d    = data_q;
      trig_d    = 1'b0;
      err_d     = err_q;

      if (bclk_rise) begin
         lr_prev_d = lrclk_s;
      end

      case (state_q)
         // HOLD leaves on any lrclk edge; a matching one restarts capture
         // directly, exactly as WAIT_CH would have.
         WAIT_CH, HOLD: begin
            if (ch_start) begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
               shift_d = {{(DATA_WIDTH-1){1'b0}}, sdata_s};
               cnt_d   = CW'(1);
               state_d = SHIFT;
`else
               shift_d = '0;
               cnt_d   = '0;
               state_d = SKIP;
`endif
            end else if ((state_q == HOLD) && lr_edge) begin
               state_d = WAIT_CH;
            end
         end
         SKIP, SHIFT: begin
            if (bclk_rise) begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
               // The edge bit already belongs to the next word.
               if (lr_edge) begin
                  state_d = EMIT;
                  err_d   = 1'b1;
               end else begin
                  shift_d = shift_in;
                  cnt_d   = cnt_inc;
                  if (cnt_inc == CNT_FULL) state_d = EMIT;
               end
`else
               // The one-bit delay puts the LSB on the edge bit itself.
               shift_d = shift_in;
               cnt_d   = cnt_inc;
               if (cnt_inc == CNT_FULL) begin
                  state_d = EMIT;
               end else if (lr_edge) begin
                  state_d = EMIT;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         EMIT: begin
            // Short words are right-packed in shift_q; left-align them.
            data_d  = shift_q << (CNT_FULL - cnt_q);
            trig_d  = 1'b1;
            state_d = HOLD;
         end
         default: state_d = WAIT_CH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WAIT_CH;
         shift_q   <= '0;
         cnt_q     <= '0;
         lr_prev_q <= 1'b0;
         data_q    <= '0;
         trig_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         lr_prev_q <= lr_prev_d;
         data_q    <= data_d;
         trig_q    <= trig_d;
         err_q     <= err_d;
      end
   end

   assign bus.data_out    = data_q;
   assign bus.sample_trig = trig_q;
   assign bus.frame_err   = err_q;
endmodule
